admm_slack_dual_update: RTL and testbench

//  ADMM slack + dual update over a full MPC horizon. Streams one knot point per beat (NX state lanes,
//  NU control lanes), computes v=clip(x+y), z=clip(u+g), y'=y+x-v, g'=g+u-z per lane, and accumulates the

---
 rtl/admm_slack_dual_update_if.sv | 56 +++++
 rtl/admm_slack_dual_update.sv | 202 ++++++++++++++++++++
 tb/tb_admm_slack_dual_update.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/admm_slack_dual_update_if.sv
// Knot-stream bus for the ADMM slack/dual update block.
// Groups the pass control, static bounds, input knot stream (x, y, u, g with
// in_valid/in_ready), result stream (v, y_new, z, g_new, out_idx with
// out_valid/out_ready) and status (prim_res, busy, done).
// master: the side that drives knots and consumes results (solver / bench).
// slave : the update block itself.
// CW must equal $clog2(NHORIZON+1) of the attached block.
interface admm_slack_dual_update_if #(
  parameter int NX = 12,
  parameter int NU = 4,
  parameter int W  = 16,
  parameter int CW = 4
);
  logic                   start;
  logic [NX-1:0][W-1:0]   x_lo;
  logic [NX-1:0][W-1:0]   x_hi;
  logic [NU-1:0][W-1:0]   u_lo;
  logic [NU-1:0][W-1:0]   u_hi;

  logic                   in_valid;
  logic                   in_ready;
  logic [NX-1:0][W-1:0]   x;
  logic [NX-1:0][W-1:0]   y;
  logic [NU-1:0][W-1:0]   u;
  logic [NU-1:0][W-1:0]   g;

  logic                   out_valid;
  logic                   out_ready;
  logic [CW-1:0]          out_idx;
  logic [NX-1:0][W-1:0]   v;
  logic [NX-1:0][W-1:0]   y_new;
  logic [NU-1:0][W-1:0]   z;
  logic [NU-1:0][W-1:0]   g_new;

  logic [W-1:0]           prim_res;
  logic                   busy;
  logic                   done;

  modport master (
    output start, x_lo, x_hi, u_lo, u_hi,
    output in_valid, x, y, u, g,
    output out_ready,
    input  in_ready,
    input  out_valid, out_idx, v, y_new, z, g_new,
    input  prim_res, busy, done
  );

  modport slave (
    input  start, x_lo, x_hi, u_lo, u_hi,
    input  in_valid, x, y, u, g,
    input  out_ready,
    output in_ready,
    output out_valid, out_idx, v, y_new, z, g_new,
    output prim_res, busy, done
  );
endinterface

// File: rtl/admm_slack_dual_update.sv
// ADMM slack + dual update over one MPC horizon.
// Per knot and lane: v = clip(x+y, x_lo, x_hi), y_new = sat(x+y-v),
// z = clip(u+g, u_lo, u_hi), g_new = sat(u+g-z). The primal residual
// max |x-v|, |u-z| over every lane of every knot is latched into prim_res
// when the pass completes.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of admm_slack_dual_update_if (start, bounds,
//                input knot stream, result stream, prim_res, busy, done)
// Two-stage pipeline (S1: sums, S2: clip/dual/residual into output regs);
// the whole pipe freezes while a result is presented but not accepted.
module admm_slack_dual_update #(
  parameter int NX       = 12,
  parameter int NU       = 4,
  parameter int W        = 16,
  parameter int NHORIZON = 10
) (
  input logic                   clk,
  input logic                   reset,
  admm_slack_dual_update_if.slave bus
);
  localparam int CW = $clog2(NHORIZON + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        in_cnt;
  logic [CW-1:0]        out_cnt;
  logic [W-1:0]         acc;

  logic                 stall;
  logic                 take;
  logic                 give;

  // Stage 1 registers: W+1-bit sums plus the primal values needed for the residual.
  logic                 s1_valid;
  logic [NX-1:0][W:0]   s1_s;
  logic [NX-1:0][W-1:0] s1_x;
  logic [NU-1:0][W:0]   s1_t;
  logic [NU-1:0][W-1:0] s1_u;

  // Stage 2 combinational results.
  logic [NX-1:0][W-1:0] v_c;
  logic [NX-1:0][W-1:0] yn_c;
  logic [NU-1:0][W-1:0] z_c;
  logic [NU-1:0][W-1:0] gn_c;
  logic [W-1:0]         res_c;
  logic [W-1:0]         lane_r;

  // min(max(s, lo), hi): with lo > hi the second step always yields hi.
  function automatic logic [W-1:0] clip(input logic signed [W:0]   s,
                                        input logic        [W-1:0] lo,
                                        input logic        [W-1:0] hi);
    logic signed [W:0] lo_e;
    logic signed [W:0] hi_e;
    logic signed [W:0] c;
    lo_e = {lo[W-1], lo};
    hi_e = {hi[W-1], hi};
    c    = s;
    if (c < lo_e) c = lo_e;
    if (c > hi_e) c = hi_e;
    return c[W-1:0];
  endfunction

  // s - c at W+2 bits, saturated to the signed W range. In range exactly when
  // the top three bits agree.
  function automatic logic [W-1:0] dual(input logic [W:0]   s,
                                        input logic [W-1:0] c);
    logic [W+1:0] d;
    d = {s[W], s} - {{2{c[W-1]}}, c};
    if (d[W+1:W-1] == 3'b000 || d[W+1:W-1] == 3'b111)
      return d[W-1:0];
    else if (d[W+1])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
  endfunction

  // |a - c| at W+1 bits, saturated to the unsigned W range.
  function automatic logic [W-1:0] resid(input logic [W-1:0] a,
                                         input logic [W-1:0] c);
    logic [W:0] d;
    logic [W:0] m;
    d = {a[W-1], a} - {c[W-1], c};
    m = d[W] ? (~d + 1'b1) : d;
    return m[W] ? '1 : m[W-1:0];
  endfunction

  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = (state == RUN) && (in_cnt < CW'(NHORIZON)) && !stall;
  assign take         = bus.in_valid && bus.in_ready;
  assign give         = bus.out_valid && bus.out_ready;
  assign bus.out_idx  = out_cnt;

  always_comb begin
    v_c    = '0;
    yn_c   = '0;
    z_c    = '0;
    gn_c   = '0;
    res_c  = '0;
    lane_r = '0;
    for (int unsigned i = 0; i < NX; i++) begin
      v_c[i]  = clip(s1_s[i], bus.x_lo[i], bus.x_hi[i]);
      yn_c[i] = dual(s1_s[i], v_c[i]);
      lane_r  = resid(s1_x[i], v_c[i]);
      if (lane_r > res_c) res_c = lane_r;
    end
    for (int unsigned i = 0; i < NU; i++) begin
      z_c[i]  = clip(s1_t[i], bus.u_lo[i], bus.u_hi[i]);
      gn_c[i] = dual(s1_t[i], z_c[i]);
      lane_r  = resid(s1_u[i], z_c[i]);
      if (lane_r > res_c) res_c = lane_r;
    end
  end

  // Datapath: both stages advance together, so a stall holds S1 and the
  // presented result in place without losing or duplicating a knot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s1_s          <= '0;
      s1_x          <= '0;
      s1_t          <= '0;
      s1_u          <= '0;
      bus.out_valid <= 1'b0;
      bus.v         <= '0;
      bus.y_new     <= '0;
      bus.z         <= '0;
      bus.g_new     <= '0;
    end else if (!stall) begin
      s1_valid <= take;
      if (take) begin
        for (int unsigned i = 0; i < NX; i++) begin
          s1_s[i] <= {bus.x[i][W-1], bus.x[i]} + {bus.y[i][W-1], bus.y[i]};
          s1_x[i] <= bus.x[i];
        end
        for (int unsigned i = 0; i < NU; i++) begin
          s1_t[i] <= {bus.u[i][W-1], bus.u[i]} + {bus.g[i][W-1], bus.g[i]};
          s1_u[i] <= bus.u[i];
        end
      end
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.v     <= v_c;
        bus.y_new <= yn_c;
        bus.z     <= z_c;
        bus.g_new <= gn_c;
      end
    end
  end

  // Pass control, knot counters, residual accumulator and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      in_cnt       <= '0;
      out_cnt      <= '0;
      acc          <= '0;
      bus.prim_res <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      if (take) in_cnt <= in_cnt + 1'b1;
      if (give) out_cnt <= out_cnt + 1'b1;
      // Accumulate as each result is loaded, so the final knot is already
      // folded in by the time it is accepted.
      if (!stall && s1_valid && res_c > acc) acc <= res_c;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            in_cnt   <= '0;
            out_cnt  <= '0;
            acc      <= '0;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          if (take && in_cnt == CW'(NHORIZON - 1)) state <= DRAIN;
        end
        DRAIN: begin
          if (give && out_cnt == CW'(NHORIZON - 1)) begin
            state        <= DONE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            bus.prim_res <= acc;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_admm_slack_dual_update.sv
// Bench for admm_slack_dual_update: fixed vectors with hand-derived results,
// stall / start-spam / reset sequences, and random passes checked against a
// plain integer model of the clip / dual / residual rules.
module tb_admm_slack_dual_update;
  localparam int NX    = 2;
  localparam int NU    = 1;
  localparam int W     = 16;
  localparam int N     = 3;
  localparam int CW    = $clog2(N + 1);
  localparam int SNAPW = 2 * NX * W + 2 * NU * W + CW;
  localparam int SMAX  = (1 << (W - 1)) - 1;
  localparam int SMIN  = -(1 << (W - 1));
  localparam int UMAX  = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  admm_slack_dual_update_if #(.NX(NX), .NU(NU), .W(W), .CW(CW)) bus ();

  admm_slack_dual_update #(.NX(NX), .NU(NU), .W(W), .NHORIZON(N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int x, y, u, g, xlo, xhi, ulo, uhi;
    int v, yn, z, gn, res;
    bit spam;
  } vec_t;

  vec_t tbl[5];

  int tests = 0;
  int fails = 0;

  int kx[N][NX], ky[N][NX], ku[N][NU], kg[N][NU];
  int xlo[NX], xhi[NX], ulo[NU], uhi[NU];
  int ev[N][NX], eyn[N][NX], ez[N][NU], egn[N][NU];
  int eres;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(UMAX)) + SMIN;
  endfunction

  function automatic int m_clip(int s, int lo, int hi);
    int c;
    c = (s < lo) ? lo : s;
    return (c > hi) ? hi : c;
  endfunction

  function automatic int m_sat(int d);
    if (d > SMAX) return SMAX;
    if (d < SMIN) return SMIN;
    return d;
  endfunction

  function automatic int m_res(int d);
    int a;
    a = (d < 0) ? -d : d;
    return (a > UMAX) ? UMAX : a;
  endfunction

  task automatic model_fill();
    int s;
    eres = 0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < NX; i++) begin
        s         = kx[k][i] + ky[k][i];
        ev[k][i]  = m_clip(s, xlo[i], xhi[i]);
        eyn[k][i] = m_sat(s - ev[k][i]);
        if (m_res(kx[k][i] - ev[k][i]) > eres) eres = m_res(kx[k][i] - ev[k][i]);
      end
      for (int i = 0; i < NU; i++) begin
        s         = ku[k][i] + kg[k][i];
        ez[k][i]  = m_clip(s, ulo[i], uhi[i]);
        egn[k][i] = m_sat(s - ez[k][i]);
        if (m_res(ku[k][i] - ez[k][i]) > eres) eres = m_res(ku[k][i] - ez[k][i]);
      end
    end
  endtask

  task automatic fill_random();
    int a, b;
    for (int i = 0; i < NX; i++) begin
      a = rnd16(); b = rnd16();
      if ($urandom_range(3) != 0 && a > b) begin xlo[i] = b; xhi[i] = a; end
      else begin xlo[i] = a; xhi[i] = b; end
    end
    for (int i = 0; i < NU; i++) begin
      a = rnd16(); b = rnd16();
      if ($urandom_range(3) != 0 && a > b) begin ulo[i] = b; uhi[i] = a; end
      else begin ulo[i] = a; uhi[i] = b; end
    end
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < NX; i++) begin kx[k][i] = rnd16(); ky[k][i] = rnd16(); end
      for (int i = 0; i < NU; i++) begin ku[k][i] = rnd16(); kg[k][i] = rnd16(); end
    end
    model_fill();
  endtask

  // Every knot and lane carries the same values; expectations come from the table row.
  task automatic fill_const(input vec_t t);
    for (int i = 0; i < NX; i++) begin xlo[i] = t.xlo; xhi[i] = t.xhi; end
    for (int i = 0; i < NU; i++) begin ulo[i] = t.ulo; uhi[i] = t.uhi; end
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < NX; i++) begin
        kx[k][i] = t.x; ky[k][i] = t.y; ev[k][i] = t.v; eyn[k][i] = t.yn;
      end
      for (int i = 0; i < NU; i++) begin
        ku[k][i] = t.u; kg[k][i] = t.g; ez[k][i] = t.z; egn[k][i] = t.gn;
      end
    end
    eres = t.res;
  endtask

  task automatic drive_bounds();
    for (int i = 0; i < NX; i++) begin bus.x_lo[i] = W'(xlo[i]); bus.x_hi[i] = W'(xhi[i]); end
    for (int i = 0; i < NU; i++) begin bus.u_lo[i] = W'(ulo[i]); bus.u_hi[i] = W'(uhi[i]); end
  endtask

  task automatic drive_knot(input int k);
    bus.in_valid = 1'b1;
    for (int i = 0; i < NX; i++) begin bus.x[i] = W'(kx[k][i]); bus.y[i] = W'(ky[k][i]); end
    for (int i = 0; i < NU; i++) begin bus.u[i] = W'(ku[k][i]); bus.g[i] = W'(kg[k][i]); end
  endtask

  task automatic drive_junk();
    bus.in_valid = 1'b0;
    for (int i = 0; i < NX; i++) begin bus.x[i] = W'($urandom); bus.y[i] = W'($urandom); end
    for (int i = 0; i < NU; i++) begin bus.u[i] = W'($urandom); bus.g[i] = W'($urandom); end
  endtask

  function automatic logic [SNAPW-1:0] snapshot();
    return {bus.v, bus.y_new, bus.z, bus.g_new, bus.out_idx};
  endfunction

  // One full pass. vprob/rprob: percent chance of in_valid / out_ready per
  // cycle; out_ready is forced low for cycles [hold_at, hold_at+hold_len);
  // spam keeps start high through the DONE cycle.
  task automatic run_pass(input string tag, input int vprob, input int rprob,
                          input bit spam, input int hold_at, input int hold_len);
    int sent, got, dones, post, cyc;
    bit prev_stall;
    logic [SNAPW-1:0] snap;
    sent = 0; got = 0; dones = 0; post = 0; cyc = 0;
    prev_stall = 1'b0;
    snap = '0;
    @(negedge clk);
    drive_bounds();
    drive_junk();
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    while (cyc < 300 && post < 4) begin
      @(negedge clk);
      cyc++;
      if (bus.done) dones++;
      if (prev_stall) begin
        chk({tag, " held_valid"}, int'(bus.out_valid), 1);
        chk({tag, " held_data_stable"}, int'(snapshot() == snap), 1);
      end
      bus.start = spam && (post == 0);
      if (dones > 0) post++;
      if (sent < N && int'($urandom_range(99)) < vprob) drive_knot(sent);
      else drive_junk();
      if (cyc >= hold_at && cyc < hold_at + hold_len) bus.out_ready = 1'b0;
      else bus.out_ready = (int'($urandom_range(99)) < rprob);
      #1;
      if (bus.out_valid && !bus.out_ready)
        chk({tag, " in_ready_in_stall"}, int'(bus.in_ready), 0);
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        if (got < N) begin
          chk($sformatf("%s k%0d out_idx", tag, got), int'(bus.out_idx), got);
          for (int i = 0; i < NX; i++) begin
            chk($sformatf("%s k%0d v[%0d]", tag, got, i), int'($signed(bus.v[i])), ev[got][i]);
            chk($sformatf("%s k%0d y_new[%0d]", tag, got, i), int'($signed(bus.y_new[i])), eyn[got][i]);
          end
          for (int i = 0; i < NU; i++) begin
            chk($sformatf("%s k%0d z[%0d]", tag, got, i), int'($signed(bus.z[i])), ez[got][i]);
            chk($sformatf("%s k%0d g_new[%0d]", tag, got, i), int'($signed(bus.g_new[i])), egn[got][i]);
          end
        end
        got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      snap = snapshot();
    end
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, " done_pulses"}, dones, 1);
    chk({tag, " results"}, got, N);
    chk({tag, " busy_after"}, int'(bus.busy), 0);
    chk({tag, " prim_res"}, int'(bus.prim_res), eres);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, " out_valid"}, int'(bus.out_valid), 0);
    chk({tag, " in_ready"}, int'(bus.in_ready), 0);
    chk({tag, " busy"}, int'(bus.busy), 0);
    chk({tag, " done"}, int'(bus.done), 0);
    chk({tag, " prim_res"}, int'(bus.prim_res), 0);
    chk({tag, " out_idx"}, int'(bus.out_idx), 0);
    chk({tag, " v0"}, int'(bus.v[0]), 0);
    chk({tag, " g_new0"}, int'(bus.g_new[0]), 0);
  endtask

  task automatic reset_mid_pass();
    bit accepted;
    int dones;
    accepted = 1'b0;
    dones = 0;
    fill_random();
    @(negedge clk);
    drive_bounds();
    drive_junk();
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && !accepted; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      drive_knot(0);
      #1;
      if (bus.in_valid && bus.in_ready) accepted = 1'b1;
    end
    chk("rst first_knot_accepted", int'(accepted), 1);
    @(negedge clk);
    drive_knot(1);
    reset = 1'b1;
    #1;
    check_quiet("rst_mid");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("rst no_done", dones, 0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_quiet("rst_after");
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x = '0; bus.y = '0; bus.u = '0; bus.g = '0;
    bus.x_lo = '0; bus.x_hi = '0; bus.u_lo = '0; bus.u_hi = '0;

    //         x       y       u       g       xlo     xhi    ulo     uhi     v      yn      z       gn      res   spam
    tbl[0] = '{10,     5,      -20,    3,      -100,   100,   -100,   100,    15,    0,      -17,    0,      5,    1'b0};
    tbl[1] = '{90,     40,     -90,    -40,    -100,   100,   -100,   100,    100,   30,     -100,   -30,    10,   1'b0};
    tbl[2] = '{32767,  32767,  -32768, -32768, -32768, 32767, -32768, 32767,  32767, 32767,  -32768, -32768, 0,    1'b0};
    tbl[3] = '{-32768, -32768, 32767,  32767,  32767,  32767, -32768, -32768, 32767, -32768, -32768, 32767,  65535, 1'b0};
    tbl[4] = '{0,      0,      70,     0,      50,     10,    50,     10,     10,    -10,    10,     60,     60,   1'b1};

    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      fill_const(tbl[t]);
      run_pass($sformatf("vec%0d", t), 100, 100, tbl[t].spam, 0, 0);
    end

    fill_random();
    run_pass("stall5", 100, 100, 1'b0, 3, 5);

    for (int r = 0; r < 8; r++) begin
      fill_random();
      run_pass($sformatf("rand%0d", r), 30 + int'($urandom_range(70)),
               30 + int'($urandom_range(70)), 1'($urandom_range(1)), 0, 0);
    end

    reset_mid_pass();
    fill_random();
    run_pass("post_reset", 100, 100, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
